// File: rtl/decode_pkg.sv
// Shared RV32I decode encodings: opcodes, control codes and operand selects
// consumed by the decode, execute and memory stages.
package decode_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0]  F7_BASE    = 7'b0000000;
   localparam logic [6:0]  F7_ALT     = 7'b0100000;
   localparam logic [31:0] INST_ECALL = 32'h0000_0073;

   typedef enum logic [4:0] {
      EXE_X = 5'd0, EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_XOR, EXE_SLL,
      EXE_SRL, EXE_SRA, EXE_SLT, EXE_SLTU, EXE_BEQ, EXE_BNE, EXE_BLT,
      EXE_BGE, EXE_BLTU, EXE_BGEU, EXE_JALR, EXE_COPY1
   } exe_fun_e;

   typedef enum logic [3:0] {
      WB_X = 4'd0, WB_ALU, WB_MEM, WB_PC, WB_CSR, WB_LB, WB_LBU, WB_LH, WB_LHU
   } wb_sel_e;

   typedef enum logic [4:0] {
      MEN_X = 5'd0, MEN_SB, MEN_SH, MEN_SW
   } mem_wen_e;

   typedef enum logic [2:0] {
      CSR_X = 3'd0, CSR_W, CSR_S, CSR_C, CSR_E
   } csr_cmd_e;

   typedef enum logic [1:0] {
      OP1_X = 2'd0, OP1_RS1, OP1_PC, OP1_IMZ
   } op1_sel_e;

   typedef enum logic [2:0] {
      OP2_X = 3'd0, OP2_RS2, OP2_IMI, OP2_SHAMT, OP2_IMS, OP2_IMJ, OP2_IMU
   } op2_sel_e;

   typedef struct packed {
      exe_fun_e exe;
      op1_sel_e op1;
      op2_sel_e op2;
      mem_wen_e mem;
      logic     rf_wen;
      wb_sel_e  wb;
      csr_cmd_e csr;
      logic     jmp;
   } ctrl_t;

   function automatic ctrl_t mk_ctrl(input exe_fun_e exe, input op1_sel_e op1,
                                     input op2_sel_e op2, input mem_wen_e mem,
                                     input logic rf_wen, input wb_sel_e wb,
                                     input csr_cmd_e csr, input logic jmp);
      mk_ctrl = '{exe: exe, op1: op1, op2: op2, mem: mem, rf_wen: rf_wen,
                  wb: wb, csr: csr, jmp: jmp};
   endfunction

   localparam ctrl_t CTRL_BUBBLE = mk_ctrl(EXE_X, OP1_X, OP2_X, MEN_X, 1'b0,
                                           WB_X, CSR_X, 1'b0);

   // alt selects SUB/SRA; the caller gates it to the encodings where it is legal
   function automatic exe_fun_e alu_fun(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_fun = alt ? EXE_SUB : EXE_ADD;
         3'b001:  alu_fun = EXE_SLL;
         3'b010:  alu_fun = EXE_SLT;
         3'b011:  alu_fun = EXE_SLTU;
         3'b100:  alu_fun = EXE_XOR;
         3'b101:  alu_fun = alt ? EXE_SRA : EXE_SRL;
         3'b110:  alu_fun = EXE_OR;
         default: alu_fun = EXE_AND;
      endcase
   endfunction

   function automatic exe_fun_e branch_fun(input logic [2:0] f3);
      case (f3)
         3'b000:  branch_fun = EXE_BEQ;
         3'b001:  branch_fun = EXE_BNE;
         3'b100:  branch_fun = EXE_BLT;
         3'b101:  branch_fun = EXE_BGE;
         3'b110:  branch_fun = EXE_BLTU;
         3'b111:  branch_fun = EXE_BGEU;
         default: branch_fun = EXE_X;
      endcase
   endfunction

   function automatic wb_sel_e load_wb(input logic [2:0] f3);
      case (f3)
         3'b000:  load_wb = WB_LB;
         3'b001:  load_wb = WB_LH;
         3'b010:  load_wb = WB_MEM;
         3'b100:  load_wb = WB_LBU;
         3'b101:  load_wb = WB_LHU;
         default: load_wb = WB_X;
      endcase
   endfunction

   function automatic mem_wen_e store_wen(input logic [2:0] f3);
      case (f3)
         3'b000:  store_wen = MEN_SB;
         3'b001:  store_wen = MEN_SH;
         3'b010:  store_wen = MEN_SW;
         default: store_wen = MEN_X;
      endcase
   endfunction

   function automatic csr_cmd_e csr_fun(input logic [1:0] f3lo);
      case (f3lo)
         2'b01:   csr_fun = CSR_W;
         2'b10:   csr_fun = CSR_S;
         2'b11:   csr_fun = CSR_C;
         default: csr_fun = CSR_X;
      endcase
   endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate generator: I/S/B/J sign-extended, U shifted,
// Z (CSR uimm) zero-extended.
module decode_imm_gen
   import decode_pkg::*;
(
   input  logic [XLEN-1:0] i_inst,
   output logic [XLEN-1:0] o_imm_i,
   output logic [XLEN-1:0] o_imm_s,
   output logic [XLEN-1:0] o_imm_b,
   output logic [XLEN-1:0] o_imm_j,
   output logic [XLEN-1:0] o_imm_u,
   output logic [XLEN-1:0] o_imm_z
);

   always_comb begin
      o_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
      o_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      o_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                 i_inst[11:8], 1'b0};
      o_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                 i_inst[30:21], 1'b0};
      o_imm_u = {i_inst[31:12], 12'b0};
      o_imm_z = {27'b0, i_inst[19:15]};
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-cycle registered decode of inst/reg_pc into ALU
// operands, immediates and control codes; unknown encodings become bubbles.
module decode_stage
   import decode_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] inst,
   input  logic [XLEN-1:0] reg_pc,
   input  logic [XLEN-1:0] regfile [0:31],
   output logic [XLEN-1:0] imm_i_sext,
   output logic [XLEN-1:0] imm_s_sext,
   output logic [XLEN-1:0] imm_b_sext,
   output logic [XLEN-1:0] imm_j_sext,
   output logic [XLEN-1:0] imm_u_shifted,
   output logic [XLEN-1:0] imm_z_uext,
   output logic [XLEN-1:0] output_reg_pc,
   output logic [4:0]      exe_fun,
   output logic [XLEN-1:0] op1_data,
   output logic [XLEN-1:0] op2_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [4:0]      mem_wen,
   output logic            rf_wen,
   output logic [3:0]      wb_sel,
   output logic [4:0]      wb_addr,
   output logic [2:0]      csr_cmd,
   output logic            jmp_flg
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [4:0]      w_rs1_addr;
   logic [4:0]      w_rs2_addr;
   logic [XLEN-1:0] w_rs1;
   logic [XLEN-1:0] w_rs2;
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_imm_z;
   logic [XLEN-1:0] w_op1;
   logic [XLEN-1:0] w_op2;
   logic            w_legal_shift_imm;
   ctrl_t           w_ctrl;

   decode_imm_gen u_imm_gen (
      .i_inst  (inst),
      .o_imm_i (w_imm_i),
      .o_imm_s (w_imm_s),
      .o_imm_b (w_imm_b),
      .o_imm_j (w_imm_j),
      .o_imm_u (w_imm_u),
      .o_imm_z (w_imm_z)
   );

   always_comb begin
      w_opcode   = inst[6:0];
      w_f3       = inst[14:12];
      w_f7       = inst[31:25];
      w_rs1_addr = inst[19:15];
      w_rs2_addr = inst[24:20];
      w_rs1      = (w_rs1_addr == 5'd0) ? '0 : regfile[w_rs1_addr];
      w_rs2      = (w_rs2_addr == 5'd0) ? '0 : regfile[w_rs2_addr];
   end

   // SLLI needs funct7 zero; SRLI/SRAI accept only base or alt funct7
   always_comb begin
      case (w_f3)
         3'b001:  w_legal_shift_imm = (w_f7 == F7_BASE);
         3'b101:  w_legal_shift_imm = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
         default: w_legal_shift_imm = 1'b1;
      endcase
   end

   always_comb begin
      w_ctrl = CTRL_BUBBLE;
      case (w_opcode)
         OPC_OP: begin
            if ((w_f7 == F7_BASE) ||
                ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))))
               w_ctrl = mk_ctrl(alu_fun(w_f3, w_f7[5]), OP1_RS1, OP2_RS2, MEN_X,
                                1'b1, WB_ALU, CSR_X, 1'b0);
         end
         OPC_OP_IMM: begin
            if (w_legal_shift_imm)
               w_ctrl = mk_ctrl(alu_fun(w_f3, (w_f3 == 3'b101) && w_f7[5]), OP1_RS1,
                                (w_f3[1:0] == 2'b01) ? OP2_SHAMT : OP2_IMI,
                                MEN_X, 1'b1, WB_ALU, CSR_X, 1'b0);
         end
         OPC_LOAD: begin
            if (load_wb(w_f3) != WB_X)
               w_ctrl = mk_ctrl(EXE_ADD, OP1_RS1, OP2_IMI, MEN_X, 1'b1,
                                load_wb(w_f3), CSR_X, 1'b0);
         end
         OPC_STORE: begin
            if (store_wen(w_f3) != MEN_X)
               w_ctrl = mk_ctrl(EXE_ADD, OP1_RS1, OP2_IMS, store_wen(w_f3), 1'b0,
                                WB_X, CSR_X, 1'b0);
         end
         OPC_BRANCH: begin
            if (branch_fun(w_f3) != EXE_X)
               w_ctrl = mk_ctrl(branch_fun(w_f3), OP1_RS1, OP2_RS2, MEN_X, 1'b0,
                                WB_X, CSR_X, 1'b0);
         end
         OPC_JAL:
            w_ctrl = mk_ctrl(EXE_ADD, OP1_PC, OP2_IMJ, MEN_X, 1'b1, WB_PC, CSR_X, 1'b1);
         OPC_JALR: begin
            if (w_f3 == 3'b000)
               w_ctrl = mk_ctrl(EXE_JALR, OP1_RS1, OP2_IMI, MEN_X, 1'b1, WB_PC,
                                CSR_X, 1'b1);
         end
         OPC_LUI:
            w_ctrl = mk_ctrl(EXE_ADD, OP1_X, OP2_IMU, MEN_X, 1'b1, WB_ALU, CSR_X, 1'b0);
         OPC_AUIPC:
            w_ctrl = mk_ctrl(EXE_ADD, OP1_PC, OP2_IMU, MEN_X, 1'b1, WB_ALU, CSR_X, 1'b0);
         OPC_SYSTEM: begin
            if (inst == INST_ECALL)
               w_ctrl = mk_ctrl(EXE_X, OP1_X, OP2_X, MEN_X, 1'b0, WB_X, CSR_E, 1'b0);
            else if (w_f3[1:0] != 2'b00)
               w_ctrl = mk_ctrl(EXE_COPY1, w_f3[2] ? OP1_IMZ : OP1_RS1, OP2_X, MEN_X,
                                1'b1, WB_CSR, csr_fun(w_f3[1:0]), 1'b0);
         end
         OPC_MISC_MEM:
            w_ctrl = CTRL_BUBBLE;
         default:
            w_ctrl = CTRL_BUBBLE;
      endcase
   end

   always_comb begin
      case (w_ctrl.op1)
         OP1_RS1: w_op1 = w_rs1;
         OP1_PC:  w_op1 = reg_pc;
         OP1_IMZ: w_op1 = w_imm_z;
         default: w_op1 = '0;
      endcase
      case (w_ctrl.op2)
         OP2_RS2:   w_op2 = w_rs2;
         OP2_IMI:   w_op2 = w_imm_i;
         OP2_SHAMT: w_op2 = {27'b0, w_imm_i[4:0]};
         OP2_IMS:   w_op2 = w_imm_s;
         OP2_IMJ:   w_op2 = w_imm_j;
         OP2_IMU:   w_op2 = w_imm_u;
         default:   w_op2 = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imm_i_sext    <= '0;
         imm_s_sext    <= '0;
         imm_b_sext    <= '0;
         imm_j_sext    <= '0;
         imm_u_shifted <= '0;
         imm_z_uext    <= '0;
         output_reg_pc <= '0;
         exe_fun       <= '0;
         op1_data      <= '0;
         op2_data      <= '0;
         rs2_data      <= '0;
         mem_wen       <= '0;
         rf_wen        <= 1'b0;
         wb_sel        <= '0;
         wb_addr       <= '0;
         csr_cmd       <= '0;
         jmp_flg       <= 1'b0;
      end else begin
         imm_i_sext    <= w_imm_i;
         imm_s_sext    <= w_imm_s;
         imm_b_sext    <= w_imm_b;
         imm_j_sext    <= w_imm_j;
         imm_u_shifted <= w_imm_u;
         imm_z_uext    <= w_imm_z;
         output_reg_pc <= reg_pc;
         exe_fun       <= w_ctrl.exe;
         op1_data      <= w_op1;
         op2_data      <= w_op2;
         rs2_data      <= w_rs2;
         mem_wen       <= w_ctrl.mem;
         rf_wen        <= w_ctrl.rf_wen;
         wb_sel        <= w_ctrl.wb;
         wb_addr       <= inst[11:7];
         csr_cmd       <= w_ctrl.csr;
         jmp_flg       <= w_ctrl.jmp;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed spec cases, a table-driven
// random reference model, and asynchronous reset behaviour.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst;
   logic [31:0] reg_pc;
   logic [31:0] regfile [0:31];
   logic [31:0] imm_i_sext, imm_s_sext, imm_b_sext, imm_j_sext, imm_u_shifted, imm_z_uext;
   logic [31:0] output_reg_pc, op1_data, op2_data, rs2_data;
   logic [4:0]  exe_fun, mem_wen, wb_addr;
   logic [3:0]  wb_sel;
   logic [2:0]  csr_cmd;
   logic        rf_wen, jmp_flg;
   logic [343:0] all_out;

   int n_vec = 0;
   int n_err = 0;

   decode_stage dut (
      .clk           (clk),
      .reset         (reset),
      .inst          (inst),
      .reg_pc        (reg_pc),
      .regfile       (regfile),
      .imm_i_sext    (imm_i_sext),
      .imm_s_sext    (imm_s_sext),
      .imm_b_sext    (imm_b_sext),
      .imm_j_sext    (imm_j_sext),
      .imm_u_shifted (imm_u_shifted),
      .imm_z_uext    (imm_z_uext),
      .output_reg_pc (output_reg_pc),
      .exe_fun       (exe_fun),
      .op1_data      (op1_data),
      .op2_data      (op2_data),
      .rs2_data      (rs2_data),
      .mem_wen       (mem_wen),
      .rf_wen        (rf_wen),
      .wb_sel        (wb_sel),
      .wb_addr       (wb_addr),
      .csr_cmd       (csr_cmd),
      .jmp_flg       (jmp_flg)
   );

   always #5 clk = ~clk;

   assign all_out = {imm_i_sext, imm_s_sext, imm_b_sext, imm_j_sext, imm_u_shifted,
                     imm_z_uext, output_reg_pc, exe_fun, op1_data, op2_data, rs2_data,
                     mem_wen, rf_wen, wb_sel, wb_addr, csr_cmd, jmp_flg};

   // Instruction pattern table: o1 0=zero 1=rs1 2=pc 3=uimm -1=dontcare;
   // o2 0=zero 1=rs2 2=imm_i 3=shamt 4=imm_s 5=imm_j 6=imm_u -1=dontcare.
   typedef struct {
      logic [31:0] mask, match;
      int exe, o1, o2, wb, mem, csr, rf, jmp;
   } pat_t;
   pat_t tbl[$];

   typedef struct {
      logic [191:0] imm;
      logic [31:0]  pc, op1, op2, rs2;
      logic [18:0]  ctrl;
      logic [4:0]   wba;
      bit           ops;
   } exp_t;

   function automatic void add(input logic [31:0] mask, input logic [31:0] match,
                               input int exe, input int o1, input int o2, input int wb,
                               input int mem, input int csr, input int rf, input int jmp);
      pat_t p;
      p.mask = mask; p.match = match; p.exe = exe; p.o1 = o1; p.o2 = o2;
      p.wb = wb; p.mem = mem; p.csr = csr; p.rf = rf; p.jmp = jmp;
      tbl.push_back(p);
   endfunction

   function automatic void build_table();
      add(32'hFE00707F, 32'h00000033,  1, 1, 1, 1, 0, 0, 1, 0); // add
      add(32'hFE00707F, 32'h40000033,  2, 1, 1, 1, 0, 0, 1, 0); // sub
      add(32'hFE00707F, 32'h00001033,  6, 1, 1, 1, 0, 0, 1, 0); // sll
      add(32'hFE00707F, 32'h00002033,  9, 1, 1, 1, 0, 0, 1, 0); // slt
      add(32'hFE00707F, 32'h00003033, 10, 1, 1, 1, 0, 0, 1, 0); // sltu
      add(32'hFE00707F, 32'h00004033,  5, 1, 1, 1, 0, 0, 1, 0); // xor
      add(32'hFE00707F, 32'h00005033,  7, 1, 1, 1, 0, 0, 1, 0); // srl
      add(32'hFE00707F, 32'h40005033,  8, 1, 1, 1, 0, 0, 1, 0); // sra
      add(32'hFE00707F, 32'h00006033,  4, 1, 1, 1, 0, 0, 1, 0); // or
      add(32'hFE00707F, 32'h00007033,  3, 1, 1, 1, 0, 0, 1, 0); // and
      add(32'h0000707F, 32'h00000013,  1, 1, 2, 1, 0, 0, 1, 0); // addi
      add(32'h0000707F, 32'h00002013,  9, 1, 2, 1, 0, 0, 1, 0); // slti
      add(32'h0000707F, 32'h00003013, 10, 1, 2, 1, 0, 0, 1, 0); // sltiu
      add(32'h0000707F, 32'h00004013,  5, 1, 2, 1, 0, 0, 1, 0); // xori
      add(32'h0000707F, 32'h00006013,  4, 1, 2, 1, 0, 0, 1, 0); // ori
      add(32'h0000707F, 32'h00007013,  3, 1, 2, 1, 0, 0, 1, 0); // andi
      add(32'hFE00707F, 32'h00001013,  6, 1, 3, 1, 0, 0, 1, 0); // slli
      add(32'hFE00707F, 32'h00005013,  7, 1, 3, 1, 0, 0, 1, 0); // srli
      add(32'hFE00707F, 32'h40005013,  8, 1, 3, 1, 0, 0, 1, 0); // srai
      add(32'h0000707F, 32'h00000003,  1, 1, 2, 5, 0, 0, 1, 0); // lb
      add(32'h0000707F, 32'h00001003,  1, 1, 2, 7, 0, 0, 1, 0); // lh
      add(32'h0000707F, 32'h00002003,  1, 1, 2, 2, 0, 0, 1, 0); // lw
      add(32'h0000707F, 32'h00004003,  1, 1, 2, 6, 0, 0, 1, 0); // lbu
      add(32'h0000707F, 32'h00005003,  1, 1, 2, 8, 0, 0, 1, 0); // lhu
      add(32'h0000707F, 32'h00000023,  1, 1, 4, 0, 1, 0, 0, 0); // sb
      add(32'h0000707F, 32'h00001023,  1, 1, 4, 0, 2, 0, 0, 0); // sh
      add(32'h0000707F, 32'h00002023,  1, 1, 4, 0, 3, 0, 0, 0); // sw
      add(32'h0000707F, 32'h00000063, 11, 1, 1, 0, 0, 0, 0, 0); // beq
      add(32'h0000707F, 32'h00001063, 12, 1, 1, 0, 0, 0, 0, 0); // bne
      add(32'h0000707F, 32'h00004063, 13, 1, 1, 0, 0, 0, 0, 0); // blt
      add(32'h0000707F, 32'h00005063, 14, 1, 1, 0, 0, 0, 0, 0); // bge
      add(32'h0000707F, 32'h00006063, 15, 1, 1, 0, 0, 0, 0, 0); // bltu
      add(32'h0000707F, 32'h00007063, 16, 1, 1, 0, 0, 0, 0, 0); // bgeu
      add(32'h0000007F, 32'h0000006F,  1, 2, 5, 3, 0, 0, 1, 1); // jal
      add(32'h0000707F, 32'h00000067, 17, 1, 2, 3, 0, 0, 1, 1); // jalr
      add(32'h0000007F, 32'h00000037,  1, 0, 6, 1, 0, 0, 1, 0); // lui
      add(32'h0000007F, 32'h00000017,  1, 2, 6, 1, 0, 0, 1, 0); // auipc
      add(32'h0000707F, 32'h00001073, 18, 1, -1, 4, 0, 1, 1, 0); // csrrw
      add(32'h0000707F, 32'h00002073, 18, 1, -1, 4, 0, 2, 1, 0); // csrrs
      add(32'h0000707F, 32'h00003073, 18, 1, -1, 4, 0, 3, 1, 0); // csrrc
      add(32'h0000707F, 32'h00005073, 18, 3, -1, 4, 0, 1, 1, 0); // csrrwi
      add(32'h0000707F, 32'h00006073, 18, 3, -1, 4, 0, 2, 1, 0); // csrrsi
      add(32'h0000707F, 32'h00007073, 18, 3, -1, 4, 0, 3, 1, 0); // csrrci
      add(32'hFFFFFFFF, 32'h00000073,  0, -1, -1, 0, 0, 4, 0, 0); // ecall
   endfunction

   function automatic exp_t model(input logic [31:0] in, input logic [31:0] pc);
      exp_t e;
      int hit = -1;
      logic [31:0] ii, is, ib, ij, iu, iz, r1, r2;
      ii = 32'($signed(in) >>> 20);
      is = (32'($signed(in) >>> 25) << 5) | 32'(in[11:7]);
      ib = (32'($signed(in) >>> 31) << 12) | (32'(in[7]) << 11) |
           (32'(in[30:25]) << 5) | (32'(in[11:8]) << 1);
      ij = (32'($signed(in) >>> 31) << 20) | (32'(in[19:12]) << 12) |
           (32'(in[20]) << 11) | (32'(in[30:21]) << 1);
      iu = in & 32'hFFFFF000;
      iz = 32'(in[19:15]);
      r1 = (in[19:15] == 5'd0) ? 32'd0 : regfile[in[19:15]];
      r2 = (in[24:20] == 5'd0) ? 32'd0 : regfile[in[24:20]];
      for (int k = 0; k < tbl.size(); k++)
         if (hit < 0 && (in & tbl[k].mask) == tbl[k].match) hit = k;
      e.imm = {ii, is, ib, ij, iu, iz};
      e.pc  = pc;
      e.rs2 = r2;
      e.wba = in[11:7];
      e.op1 = 32'd0;
      e.op2 = 32'd0;
      e.ops = 1'b0;
      if (hit < 0) begin
         e.ctrl = '0;
      end else begin
         e.ctrl = {5'(tbl[hit].exe), 5'(tbl[hit].mem), 1'(tbl[hit].rf),
                   4'(tbl[hit].wb), 3'(tbl[hit].csr), 1'(tbl[hit].jmp)};
         e.ops = (tbl[hit].o1 >= 0) && (tbl[hit].o2 >= 0);
         case (tbl[hit].o1)
            1: e.op1 = r1;
            2: e.op1 = pc;
            3: e.op1 = iz;
            default: e.op1 = 32'd0;
         endcase
         case (tbl[hit].o2)
            1: e.op2 = r2;
            2: e.op2 = ii;
            3: e.op2 = ii & 32'h1F;
            4: e.op2 = is;
            5: e.op2 = ij;
            6: e.op2 = iu;
            default: e.op2 = 32'd0;
         endcase
         if (tbl[hit].o1 >= 0 && tbl[hit].o2 < 0) e.ops = 1'b0;
      end
      return e;
   endfunction

   task automatic drive(input logic [31:0] i, input logic [31:0] pc);
      inst = i;
      reg_pc = pc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2 reset = 1'b1;
      inst = 32'hFFB10093;
      reg_pc = 32'h1234;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL reset_all got=%h exp=0", all_out); end
      reset = 1'b0;
   endtask

   task automatic test_addi();
      regfile[2] = 32'd1000;
      drive(32'hFFB10093, 32'h40);
      n_vec++; if (op1_data !== 32'd1000) begin n_err++; $display("FAIL addi_op1 got=%h exp=%h", op1_data, 32'd1000); end
      n_vec++; if (op2_data !== 32'hFFFFFFFB) begin n_err++; $display("FAIL addi_op2 got=%h exp=fffffffb", op2_data); end
      n_vec++; if (exe_fun !== 5'd1) begin n_err++; $display("FAIL addi_exe got=%0d exp=1", exe_fun); end
      n_vec++; if (wb_sel !== 4'd1 || rf_wen !== 1'b1) begin n_err++; $display("FAIL addi_wb got=%0d/%0d exp=1/1", wb_sel, rf_wen); end
      n_vec++; if (wb_addr !== 5'd1) begin n_err++; $display("FAIL addi_rd got=%0d exp=1", wb_addr); end
      n_vec++; if (output_reg_pc !== 32'h40) begin n_err++; $display("FAIL addi_pc got=%h exp=40", output_reg_pc); end
   endtask

   task automatic test_store();
      regfile[3] = 32'h55;
      drive(32'h00312423, 32'h44);
      n_vec++; if (op2_data !== 32'd8) begin n_err++; $display("FAIL sw_op2 got=%h exp=8", op2_data); end
      n_vec++; if (rs2_data !== 32'h55) begin n_err++; $display("FAIL sw_rs2 got=%h exp=55", rs2_data); end
      n_vec++; if (mem_wen !== 5'd3 || rf_wen !== 1'b0) begin n_err++; $display("FAIL sw_ctl got=%0d/%0d exp=3/0", mem_wen, rf_wen); end
   endtask

   task automatic test_jal();
      drive(32'h010000EF, 32'h100);
      n_vec++; if (op1_data !== 32'h100) begin n_err++; $display("FAIL jal_op1 got=%h exp=100", op1_data); end
      n_vec++; if (op2_data !== 32'd16) begin n_err++; $display("FAIL jal_op2 got=%h exp=10", op2_data); end
      n_vec++; if (wb_sel !== 4'd3 || jmp_flg !== 1'b1) begin n_err++; $display("FAIL jal_ctl got=%0d/%0d exp=3/1", wb_sel, jmp_flg); end
   endtask

   task automatic test_branch();
      drive(32'hFE000EE3, 32'h200);
      n_vec++; if (exe_fun !== 5'd11) begin n_err++; $display("FAIL beq_exe got=%0d exp=11", exe_fun); end
      n_vec++; if (op1_data !== 32'd0 || op2_data !== 32'd0) begin n_err++; $display("FAIL beq_ops got=%h/%h exp=0/0", op1_data, op2_data); end
      n_vec++; if (imm_b_sext !== 32'hFFFFFFFC) begin n_err++; $display("FAIL beq_immb got=%h exp=fffffffc", imm_b_sext); end
   endtask

   task automatic test_bubble();
      drive(32'hFFFFFFFF, 32'h300);
      n_vec++; if ({exe_fun, mem_wen, rf_wen, wb_sel, csr_cmd, jmp_flg} !== 19'd0) begin n_err++; $display("FAIL bub_ctl got=%h exp=0", {exe_fun, mem_wen, rf_wen, wb_sel, csr_cmd, jmp_flg}); end
      n_vec++; if (imm_i_sext !== 32'hFFFFFFFF || wb_addr !== 5'd31 || output_reg_pc !== 32'h300) begin n_err++; $display("FAIL bub_data got=%h/%0d/%h exp=ffffffff/31/300", imm_i_sext, wb_addr, output_reg_pc); end
      drive(32'h0FF0000F, 32'h304);
      n_vec++; if ({exe_fun, mem_wen, rf_wen, wb_sel, csr_cmd, jmp_flg} !== 19'd0) begin n_err++; $display("FAIL fence_ctl got=%h exp=0", {exe_fun, mem_wen, rf_wen, wb_sel, csr_cmd, jmp_flg}); end
      drive(32'h00000073, 32'h308);
      n_vec++; if (csr_cmd !== 3'd4 || rf_wen !== 1'b0 || exe_fun !== 5'd0) begin n_err++; $display("FAIL ecall got=%0d/%0d/%0d exp=4/0/0", csr_cmd, rf_wen, exe_fun); end
   endtask

   task automatic test_random();
      exp_t e;
      logic [31:0] r;
      int k;
      for (int n = 0; n < 600; n++) begin
         regfile[$urandom_range(31, 1)] = $urandom;
         regfile[0] = $urandom | 32'h1;
         r = $urandom;
         if ($urandom_range(4, 0) != 0) begin
            k = $urandom_range(tbl.size() - 1, 0);
            r = (r & ~tbl[k].mask) | tbl[k].match;
         end
         reg_pc = $urandom & 32'hFFFFFFFC;
         e = model(r, reg_pc);
         drive(r, reg_pc);
         n_vec++; if ({imm_i_sext, imm_s_sext, imm_b_sext, imm_j_sext, imm_u_shifted, imm_z_uext} !== e.imm) begin n_err++; $display("FAIL rnd_imm inst=%h got=%h exp=%h", r, {imm_i_sext, imm_s_sext, imm_b_sext, imm_j_sext, imm_u_shifted, imm_z_uext}, e.imm); end
         n_vec++; if ({exe_fun, mem_wen, rf_wen, wb_sel, csr_cmd, jmp_flg} !== e.ctrl) begin n_err++; $display("FAIL rnd_ctrl inst=%h got=%h exp=%h", r, {exe_fun, mem_wen, rf_wen, wb_sel, csr_cmd, jmp_flg}, e.ctrl); end
         n_vec++; if (output_reg_pc !== e.pc) begin n_err++; $display("FAIL rnd_pc inst=%h got=%h exp=%h", r, output_reg_pc, e.pc); end
         n_vec++; if (rs2_data !== e.rs2) begin n_err++; $display("FAIL rnd_rs2 inst=%h got=%h exp=%h", r, rs2_data, e.rs2); end
         n_vec++; if (wb_addr !== e.wba) begin n_err++; $display("FAIL rnd_rd inst=%h got=%0d exp=%0d", r, wb_addr, e.wba); end
         if (e.ops) begin
            n_vec++; if (op1_data !== e.op1 || op2_data !== e.op2) begin n_err++; $display("FAIL rnd_ops inst=%h got=%h/%h exp=%h/%h", r, op1_data, op2_data, e.op1, e.op2); end
         end
      end
   endtask

   task automatic test_midstream_reset();
      regfile[2] = 32'd77;
      drive(32'hFFB10093, 32'h500);
      n_vec++; if (rf_wen !== 1'b1) begin n_err++; $display("FAIL pre_rst got=%0d exp=1", rf_wen); end
      #3 reset = 1'b1;
      #1;
      n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL rst_async got=%h exp=0", all_out); end
      @(posedge clk);
      #1;
      n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL rst_hold got=%h exp=0", all_out); end
      reset = 1'b0;
      regfile[3] = 32'hA5A5;
      drive(32'h00312423, 32'h600);
      n_vec++; if (mem_wen !== 5'd3 || rs2_data !== 32'hA5A5 || output_reg_pc !== 32'h600) begin n_err++; $display("FAIL rst_first got=%0d/%h/%h exp=3/a5a5/600", mem_wen, rs2_data, output_reg_pc); end
   endtask

   initial begin
      inst = '0;
      reg_pc = '0;
      for (int i = 0; i < 32; i++) regfile[i] = $urandom;
      regfile[0] = 32'hDEADBEEF;
      build_table();
      test_reset();
      test_addi();
      test_store();
      test_jal();
      test_branch();
      test_bubble();
      test_random();
      test_midstream_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  clock, all outputs update on the rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 inst  in  32  instruction from fetch.
REQ-005 reg_pc  in  32  PC of inst.
REQ-006 regfile  in  32x32  architectural register array, read combinationally.
REQ-007 imm_i_sext, imm_s_sext, imm_b_sext, imm_j_sext, imm_u_shifted, imm_z_uext  out  32 each  registered immediates.
REQ-008 output_reg_pc  out  32  registered reg_pc.
REQ-009 exe_fun  out  5  ALU op code.
REQ-010 op1_data, op2_data, rs2_data  out  32 each  ALU operands and store data.
REQ-011 mem_wen  out  5  store code; rf_wen  out  1  register write enable; wb_sel  out  4  writeback source; wb_addr  out  5  rd.
REQ-012 csr_cmd  out  3  CSR command; jmp_flg  out  1  JAL/JALR indicator.

Function
REQ-013 Latency SHALL be one cycle: outputs reflect the inst/reg_pc/regfile sampled at the previous rising edge; no stall or flush input.
REQ-014 Immediates: I = sext inst[31:20]; S = sext {inst[31:25],inst[11:7]}; B = sext {inst[31],inst[7],inst[30:25],inst[11:8],0}; J = sext {inst[31],inst[19:12],inst[20],inst[30:21],0}; U = {inst[31:12],12'b0}; Z = zext inst[19:15].
REQ-015 rs1/rs2 reads SHALL return 0 when the index is 0, else regfile[index]; rs2_data always carries the rs2 read.
REQ-016 exe_fun codes: X=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, BEQ=11, BNE=12, BLT=13, BGE=14, BLTU=15, BGEU=16, JALR=17, COPY1=18.
REQ-017 wb_sel codes: X=0, ALU=1, MEM(LW)=2, PC=3, CSR=4, LB=5, LBU=6, LH=7, LHU=8; mem_wen: X=0, SB=1, SH=2, SW=3; csr_cmd: X=0, W=1, S=2, C=3, E=4.
REQ-018 OP/OP-IMM: op1=rs1, op2=rs2 or imm_i (shamt=imm_i[4:0]), matching ALU op, wb ALU, rf_wen 1.
REQ-019 LOAD: op1=rs1, op2=imm_i, ADD, wb per width, rf_wen 1; STORE: op1=rs1, op2=imm_s, ADD, mem_wen per width, rf_wen 0.
REQ-020 BRANCH: op1=rs1, op2=rs2, branch exe_fun, rf_wen 0, wb X.
REQ-021 JAL: op1=pc, op2=imm_j, ADD, wb PC, rf_wen 1, jmp_flg 1; JALR: op1=rs1, op2=imm_i, JALR, wb PC, rf_wen 1, jmp_flg 1.
REQ-022 LUI: op1=0, op2=imm_u, ADD; AUIPC: op1=pc, op2=imm_u, ADD; both wb ALU, rf_wen 1.
REQ-023 CSRRW/S/C: op1=rs1; CSRRWI/SI/CI: op1=imm_z; exe_fun COPY1, wb CSR, rf_wen 1, csr_cmd W/S/C.
REQ-024 ECALL: csr_cmd E, rf_wen 0, exe_fun X; FENCE decodes as bubble.
REQ-025 Any unrecognised encoding SHALL produce a bubble: all control outputs 0, data outputs still latched.
REQ-026 wb_addr SHALL equal inst[11:7] regardless of rf_wen.

Reset
REQ-027 While reset is high every output SHALL be 0 (bubble), taking effect immediately, including mid-stream.
REQ-028 The first edge after reset deassertion SHALL register the current inst normally.

Structure
REQ-029 exe_fun, wb_sel, mem_wen, csr_cmd encodings and opcode constants SHALL live in shared package decode_pkg, used by execute/memory stages too.
REQ-030 Immediate generation SHALL be one combinational sub-module, decode_imm_gen.

Verification
REQ-031 addi x1,x2,-5 (0xFFB10093), x2=1000 -> op1 1000, op2 0xFFFFFFFB, exe_fun 1, wb 1, rf_wen 1, wb_addr 1.
REQ-032 sw x3,8(x2) (0x00312423), x3=0x55 -> op2 8, rs2_data 0x55, mem_wen 3, rf_wen 0.
REQ-033 jal x1,+16 at pc 0x100 (0x010000EF) -> op1 0x100, op2 16, wb 3, jmp_flg 1.
REQ-034 beq x0,x0,-4 (0xFE000EE3) -> exe_fun 11, op1 0, op2 0, imm_b_sext 0xFFFFFFFC.
REQ-035 inst 0xFFFFFFFF -> bubble; reset asserted mid-operation -> all outputs 0 immediately.
